// File: rtl/sram_like_pkg.sv
// Shared definitions for the cache-side sram-like data interface:
// size encodings, byte-lane mask generation and lane-to-bit expansion.
package sram_like_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE     = 2'd0,
    SZ_HALF     = 2'd1,
    SZ_WORD     = 2'd2,
    SZ_WORD_ALT = 2'd3
  } sram_size_e;

  // Half accesses ignore addr[0]; word accesses ignore addr[1:0].
  function automatic logic [3:0] byte_mask(input logic [1:0] size, input logic [1:0] a_lo);
    logic [3:0] m;
    case (size)
      SZ_BYTE: m = 4'b0001 << a_lo;
      SZ_HALF: m = a_lo[1] ? 4'b1100 : 4'b0011;
      default: m = 4'b1111;
    endcase
    return m;
  endfunction

  function automatic logic [31:0] mask_to_bits(input logic [3:0] m);
    return {{8{m[3]}}, {8{m[2]}}, {8{m[1]}}, {8{m[0]}}};
  endfunction

endpackage

// File: rtl/sram_like_if.sv
// Request/response signal bundle between a data cache (master) and its
// memory-side responder (slave).
interface sram_like_if;
  logic        req;
  logic        wr;
  logic [1:0]  size;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        addr_ok;
  logic        data_ok;

  modport master (
    output req, wr, size, addr, wdata,
    input  rdata, addr_ok, data_ok
  );

  modport slave (
    input  req, wr, size, addr, wdata,
    output rdata, addr_ok, data_ok
  );
endinterface

// File: rtl/sram_like_resp_q.sv
// Two-entry in-order response queue; each entry carries a word and a
// saturating countdown that gates when it may complete at the head.
module sram_like_resp_q #(
  parameter int DATA_LAT = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        push_i,
  input  logic [31:0] push_data_i,
  input  logic        pop_i,
  output logic        head_rdy_o,
  output logic [31:0] head_data_o,
  output logic [1:0]  occ_o
);

  localparam int CW = (DATA_LAT > 1) ? $clog2(DATA_LAT) : 1;
  localparam logic [CW-1:0] CNT_INIT = CW'(DATA_LAT - 1);

  logic [1:0]    vld_q, vld_d;
  logic [CW-1:0] cnt_q  [2];
  logic [CW-1:0] cnt_d  [2];
  logic [CW-1:0] cnt_dec[2];
  logic [31:0]   data_q [2];
  logic [31:0]   data_d [2];

  // Slot 0 is always the head; a pop shifts slot 1 down before any push lands.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      cnt_dec[i] = (cnt_q[i] != '0) ? cnt_q[i] - CW'(1) : '0;
    end
    vld_d  = vld_q;
    cnt_d  = cnt_dec;
    data_d = data_q;
    if (pop_i) begin
      vld_d     = {1'b0, vld_q[1]};
      cnt_d[0]  = cnt_dec[1];
      data_d[0] = data_q[1];
    end
    if (push_i) begin
      if (!vld_d[0]) begin
        vld_d[0]  = 1'b1;
        cnt_d[0]  = CNT_INIT;
        data_d[0] = push_data_i;
      end else begin
        vld_d[1]  = 1'b1;
        cnt_d[1]  = CNT_INIT;
        data_d[1] = push_data_i;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      vld_q <= '0;
      for (int i = 0; i < 2; i++) begin
        cnt_q[i]  <= '0;
        data_q[i] <= '0;
      end
    end else begin
      vld_q <= vld_d;
      for (int i = 0; i < 2; i++) begin
        cnt_q[i]  <= cnt_d[i];
        data_q[i] <= data_d[i];
      end
    end
  end

  assign head_rdy_o  = vld_q[0] & (cnt_q[0] == '0);
  assign head_data_o = data_q[0];
  assign occ_o       = {1'b0, vld_q[0]} + {1'b0, vld_q[1]};

endmodule

// File: rtl/sram_like_mem.sv
// Sram-like responder: local word RAM with byte-masked writes, programmable
// accept wait states and in-order responses after a fixed data latency.
module sram_like_mem
  import sram_like_pkg::*;
#(
  parameter int ADDR_WIDTH = 12,
  parameter int ADDR_LAT   = 0,
  parameter int DATA_LAT   = 2
) (
  input  logic       clk,
  input  logic       resetn,
  sram_like_if.slave bus
);

  logic [31:0]           ram_q [2**ADDR_WIDTH];
  logic [ADDR_WIDTH-1:0] word_idx;
  logic [31:0]           bit_mask;
  logic                  lat_met;
  logic                  q_full;
  logic                  accept;
  logic                  data_ok;
  logic                  head_rdy;
  logic [31:0]           head_data;
  logic [1:0]            occ;
  logic [31:0]           push_word;
  logic                  unused_addr_hi;

  assign word_idx       = bus.addr[ADDR_WIDTH+1:2];
  assign unused_addr_hi = ^bus.addr[31:ADDR_WIDTH+2];
  assign bit_mask       = mask_to_bits(byte_mask(bus.size, bus.addr[1:0]));

  generate
    if (ADDR_LAT == 0) begin : g_no_wait
      assign lat_met = 1'b1;
    end else begin : g_wait
      localparam int WCW = $clog2(ADDR_LAT + 1);
      logic [WCW-1:0] wait_cnt_q, wait_cnt_d;

      always_comb begin
        wait_cnt_d = wait_cnt_q;
        if (!bus.req || accept) begin
          wait_cnt_d = '0;
        end else if (wait_cnt_q != WCW'(ADDR_LAT)) begin
          wait_cnt_d = wait_cnt_q + WCW'(1);
        end
      end

      always_ff @(posedge clk) begin
        if (!resetn) wait_cnt_q <= '0;
        else         wait_cnt_q <= wait_cnt_d;
      end

      // Counter saturates at ADDR_LAT, so equality is the ">=" test.
      assign lat_met = (wait_cnt_q == WCW'(ADDR_LAT));
    end
  endgenerate

  // A pop this cycle does not free the slot for an accept until next cycle.
  assign q_full = (occ == 2'd2);
  assign accept = resetn & bus.req & lat_met & ~q_full;

  always_ff @(posedge clk) begin
    if (accept && bus.wr) begin
      ram_q[word_idx] <= (ram_q[word_idx] & ~bit_mask) | (bus.wdata & bit_mask);
    end
  end

  assign push_word = bus.wr ? 32'h0 : ram_q[word_idx];

  sram_like_resp_q #(
    .DATA_LAT (DATA_LAT)
  ) u_resp_q (
    .clk         (clk),
    .resetn      (resetn),
    .push_i      (accept),
    .push_data_i (push_word),
    .pop_i       (data_ok),
    .head_rdy_o  (head_rdy),
    .head_data_o (head_data),
    .occ_o       (occ)
  );

  assign data_ok     = resetn & head_rdy;
  assign bus.addr_ok = accept;
  assign bus.data_ok = data_ok;
  assign bus.rdata   = data_ok ? head_data : 32'h0;

endmodule
